// File: rtl/rsbus_ring_tx.sv
// Ring-bus packet transmitter: per-lane store-and-forward FIFOs feeding the 72-bit stb/sof/data ring.
// Optional lane-0 anti-starvation aging is enabled by defining RSBUS_TX_AGING_EN.
module rsbus_ring_tx #(
    parameter int DEPTH     = 32,
    parameter int AGE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_stb,
    input  logic        s_sof,
    input  logic [71:0] s_data,
    output logic        s_rdy,
    output logic        o_stb,
    output logic        o_sof,
    output logic [71:0] o_data,
    input  logic [1:0]  o_af,
    output logic        ff_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] RDY_MAX = CW'(DEPTH - 16);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);

    typedef enum logic {PIDLE, PBODY} pstate_t;
    typedef enum logic {OIDLE, OSEND} ostate_t;

    pstate_t            pstate_q, pstate_d;
    ostate_t            ostate_q, ostate_d;
    logic [3:0]         rem_in_q, rem_in_d;
    logic [3:0]         rem_out_q, rem_out_d;
    logic               lane_in_q, lane_in_d;
    logic               lane_out_q, lane_out_d;
    logic [1:0][AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0][AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0][CW-1:0] occ_q, occ_d;
    logic [1:0][CW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [1:0]         inc_q, inc_d;
    logic               o_stb_q, o_stb_d;
    logic               o_sof_q, o_sof_d;
    logic [71:0]        o_data_q, o_data_d;
    logic               err_q, err_d;

    logic [1:0]         dec;
    logic [1:0]         pop;
    logic               wr_en, wr_ok, wr_lane;
    logic               elig0, elig1, sel0, sel1;
    logic [71:0]        head [2];

`ifdef RSBUS_TX_AGING_EN
    localparam int GW = $clog2(AGE_LIMIT + 1);
    logic [GW-1:0]      age_q, age_d;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [71:0] mem [DEPTH];
            always_ff @(posedge clk) begin
                if (wr_ok && (wr_lane == 1'(gi)))
                    mem[wr_ptr_q[gi]] <= s_data;
            end
            assign head[gi] = mem[rd_ptr_q[gi]];
        end
    endgenerate

    // Both lanes must be able to absorb a worst-case 16-beat packet.
    assign s_rdy  = (occ_q[0] <= RDY_MAX) && (occ_q[1] <= RDY_MAX);
    assign o_stb  = o_stb_q;
    assign o_sof  = o_sof_q;
    assign o_data = o_data_q;
    assign ff_err = err_q;

    always_comb begin
        pstate_d   = pstate_q;
        ostate_d   = ostate_q;
        rem_in_d   = rem_in_q;
        rem_out_d  = rem_out_q;
        lane_in_d  = lane_in_q;
        lane_out_d = lane_out_q;
        o_stb_d    = o_stb_q;
        o_sof_d    = o_sof_q;
        o_data_d   = o_data_q;
        err_d      = err_q;
        inc_d      = 2'b00;
        dec        = 2'b00;
        pop        = 2'b00;
        wr_en      = 1'b0;
        wr_lane    = lane_in_q;
        sel0       = 1'b0;
        sel1       = 1'b0;
        elig0      = (pkt_cnt_q[0] != '0) && !o_af[0];
        elig1      = (pkt_cnt_q[1] != '0) && !o_af[1];
`ifdef RSBUS_TX_AGING_EN
        age_d      = age_q;
`endif

        case (pstate_q)
            PIDLE: begin
                if (s_stb && s_rdy) begin
                    if (s_sof) begin
                        wr_en     = 1'b1;
                        wr_lane   = s_data[64];
                        lane_in_d = s_data[64];
                        rem_in_d  = s_data[63:60];
                        if (s_data[63:60] == 4'd0)
                            inc_d[s_data[64]] = 1'b1;
                        else
                            pstate_d = PBODY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            PBODY: begin
                if (s_stb && s_rdy) begin
                    wr_en    = 1'b1;
                    rem_in_d = rem_in_q - 4'd1;
                    if (s_sof)
                        err_d = 1'b1;
                    if (rem_in_q == 4'd1) begin
                        inc_d[lane_in_q] = 1'b1;
                        pstate_d         = PIDLE;
                    end
                end
            end
            default: pstate_d = PIDLE;
        endcase

        wr_ok = wr_en && (occ_q[wr_lane] != FULL);
        if (wr_en && !wr_ok)
            err_d = 1'b1;

        case (ostate_q)
            OIDLE: begin
                o_stb_d = 1'b0;
                o_sof_d = 1'b0;
`ifdef RSBUS_TX_AGING_EN
                sel0 = elig0 && (!elig1 || (age_q >= GW'(AGE_LIMIT)));
                sel1 = elig1 && !sel0;
                if (sel0)
                    age_d = '0;
                else if (sel1 && elig0 && (age_q < GW'(AGE_LIMIT)))
                    age_d = age_q + GW'(1);
`else
                sel1 = elig1;
                sel0 = elig0 && !elig1;
`endif
                if (sel0 || sel1) begin
                    lane_out_d = sel1;
                    dec[sel1]  = 1'b1;
                    pop[sel1]  = 1'b1;
                    o_stb_d    = 1'b1;
                    o_sof_d    = 1'b1;
                    o_data_d   = head[sel1];
                    rem_out_d  = head[sel1][63:60];
                    ostate_d   = OSEND;
                end
            end
            OSEND: begin
                // rem reaching zero here yields the mandatory idle cycle between packets.
                if (rem_out_q == 4'd0) begin
                    o_stb_d  = 1'b0;
                    o_sof_d  = 1'b0;
                    ostate_d = OIDLE;
                end else begin
                    pop[lane_out_q] = 1'b1;
                    o_stb_d         = 1'b1;
                    o_sof_d         = 1'b0;
                    o_data_d        = head[lane_out_q];
                    rem_out_d       = rem_out_q - 4'd1;
                end
            end
            default: ostate_d = OIDLE;
        endcase

        for (int i = 0; i < 2; i++) begin
            wr_ptr_d[i]  = wr_ptr_q[i] + AW'(wr_ok && (wr_lane == 1'(i)));
            rd_ptr_d[i]  = rd_ptr_q[i] + AW'(pop[i]);
            occ_d[i]     = occ_q[i] + CW'(wr_ok && (wr_lane == 1'(i))) - CW'(pop[i]);
            pkt_cnt_d[i] = pkt_cnt_q[i] + CW'(inc_q[i]) - CW'(dec[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pstate_q   <= PIDLE;
            ostate_q   <= OIDLE;
            rem_in_q   <= '0;
            rem_out_q  <= '0;
            lane_in_q  <= 1'b0;
            lane_out_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            pkt_cnt_q  <= '0;
            inc_q      <= '0;
            o_stb_q    <= 1'b0;
            o_sof_q    <= 1'b0;
            o_data_q   <= '0;
            err_q      <= 1'b0;
`ifdef RSBUS_TX_AGING_EN
            age_q      <= '0;
`endif
        end else begin
            pstate_q   <= pstate_d;
            ostate_q   <= ostate_d;
            rem_in_q   <= rem_in_d;
            rem_out_q  <= rem_out_d;
            lane_in_q  <= lane_in_d;
            lane_out_q <= lane_out_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            pkt_cnt_q  <= pkt_cnt_d;
            inc_q      <= inc_d;
            o_stb_q    <= o_stb_d;
            o_sof_q    <= o_sof_d;
            o_data_q   <= o_data_d;
            err_q      <= err_d;
`ifdef RSBUS_TX_AGING_EN
            age_q      <= age_d;
`endif
        end
    end

endmodule

// File: tb/tb_rsbus_ring_tx.sv
// Self-checking bench for rsbus_ring_tx: queue-based packet model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic and backpressure.
module tb_rsbus_ring_tx;

    localparam int DEPTH     = 32;
    localparam int AGE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_stb = 1'b0;
    logic        s_sof = 1'b0;
    logic [71:0] s_data = '0;
    logic        s_rdy;
    logic        o_stb;
    logic        o_sof;
    logic [71:0] o_data;
    logic [1:0]  o_af = 2'b00;
    logic        ff_err;

    always #5 clk = ~clk;

    rsbus_ring_tx #(.DEPTH(DEPTH), .AGE_LIMIT(AGE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .s_stb(s_stb), .s_sof(s_sof), .s_data(s_data), .s_rdy(s_rdy),
        .o_stb(o_stb), .o_sof(o_sof), .o_data(o_data),
        .o_af(o_af), .ff_err(ff_err)
    );

    int n_vec = 0;
    int n_mis = 0;

    // Behavioural model: lane queues of stored beats, completed-packet counts.
    logic [71:0] mq0 [$];
    logic [71:0] mq1 [$];
    logic [72:0] gq [$];
    int          pk [2];
    int          pend [2];
    bit          in_pkt;
    int          cur_lane;
    int          left;
    int          tx_lane;
    int          tx_left;
    int          age;
    bit          e_stb, e_sof, e_err;
    logic [71:0] e_data;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic int msize(input int lane);
        return (lane == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic bit m_rdy();
        return (mq0.size() <= DEPTH - 16) && (mq1.size() <= DEPTH - 16);
    endfunction

    function automatic logic [71:0] mpop(input int lane);
        if (lane == 0) return mq0.pop_front();
        return mq1.pop_front();
    endfunction

    task automatic mpush(input int lane, input logic [71:0] d);
        if (msize(lane) >= DEPTH) e_err = 1'b1;
        else if (lane == 0) mq0.push_back(d);
        else mq1.push_back(d);
    endtask

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        pk[0] = 0; pk[1] = 0; pend[0] = 0; pend[1] = 0;
        in_pkt = 1'b0; cur_lane = 0; left = 0;
        tx_lane = 0; tx_left = 0; age = 0;
        e_stb = 1'b0; e_sof = 1'b0; e_err = 1'b0; e_data = '0;
    endtask

    // Predict the outputs registered at the next clock edge for the given inputs.
    task automatic advance(input bit stb, input bit sof, input logic [71:0] d, input logic [1:0] af);
        bit rdy;
        bit el0, el1;
        int pick;
        int done [2];
        rdy = m_rdy();
        done[0] = 0; done[1] = 0;
        if (tx_left > 0) begin
            e_data = mpop(tx_lane);
            e_stb = 1'b1; e_sof = 1'b0;
            tx_left--;
        end else if (e_stb) begin
            e_stb = 1'b0; e_sof = 1'b0;
        end else begin
            el0 = (pk[0] > 0) && !af[0];
            el1 = (pk[1] > 0) && !af[1];
            pick = -1;
            if (el1) pick = 1;
            else if (el0) pick = 0;
`ifdef RSBUS_TX_AGING_EN
            if (el0 && el1 && age >= AGE_LIMIT) pick = 0;
            if (pick == 0) age = 0;
            else if (pick == 1 && el0 && age < AGE_LIMIT) age++;
`endif
            if (pick >= 0) begin
                pk[pick]--;
                tx_lane = pick;
                e_data = mpop(pick);
                e_stb = 1'b1; e_sof = 1'b1;
                tx_left = int'(e_data[63:60]);
            end
        end
        if (stb && rdy) begin
            if (!in_pkt) begin
                if (sof) begin
                    cur_lane = int'(d[64]);
                    mpush(cur_lane, d);
                    left = int'(d[63:60]);
                    if (left == 0) done[cur_lane]++;
                    else in_pkt = 1'b1;
                end else begin
                    e_err = 1'b1;
                end
            end else begin
                mpush(cur_lane, d);
                if (sof) e_err = 1'b1;
                left--;
                if (left == 0) begin
                    done[cur_lane]++;
                    in_pkt = 1'b0;
                end
            end
        end
        // A completed packet becomes eligible for arbitration one cycle after its last write.
        for (int l = 0; l < 2; l++) begin
            pk[l] += pend[l];
            pend[l] = done[l];
        end
    endtask

    task automatic compare();
        chk("o_stb", 72'(o_stb), 72'(e_stb));
        chk("o_sof", 72'(o_sof), 72'(e_sof));
        if (e_stb) chk("o_data", o_data, e_data);
        chk("ff_err", 72'(ff_err), 72'(e_err));
        chk("s_rdy", 72'(s_rdy), 72'(m_rdy()));
    endtask

    task automatic cycle(input bit stb, input bit sof, input logic [71:0] d, input logic [1:0] af);
        compare();
        s_stb = stb; s_sof = sof; s_data = d; o_af = af;
        advance(stb, sof, d, af);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic [1:0] af);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 72'h0, af);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_stb = 1'b0; s_sof = 1'b0; s_data = '0;
        #1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        gq.delete();
    endtask

    function automatic logic [71:0] mk_hdr(input bit lane, input logic [3:0] len, input logic [59:0] tag);
        return {7'h0, lane, len, tag};
    endfunction

    task automatic gen_pkt();
        logic [63:0] r;
        logic [95:0] b;
        bit          lane;
        logic [3:0]  len;
        if ($urandom_range(0, 39) == 0) begin
            b = {$urandom, $urandom, $urandom};
            gq.push_back({1'b0, b[71:0]});
        end
        lane = 1'($urandom_range(0, 1));
        len  = 4'($urandom_range(0, 15));
        r = {$urandom, $urandom};
        gq.push_back({1'b1, 7'($urandom), lane, len, r[59:0]});
        for (int i = 0; i < int'(len); i++) begin
            b = {$urandom, $urandom, $urandom};
            gq.push_back({($urandom_range(0, 49) == 0), b[71:0]});
        end
    endtask

    initial begin
        logic [71:0] hdr, h0, h1;
        logic [71:0] bd [3];
        logic [72:0] ent;
        logic [1:0]  cur_af;
        bit          stb, acc;
        int          n1, found, exp_n1;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        chk("rst_o_stb", 72'(o_stb), 72'h0);
        chk("rst_o_sof", 72'(o_sof), 72'h0);
        chk("rst_o_data", o_data, 72'h0);
        chk("rst_ff_err", 72'(ff_err), 72'h0);
        chk("rst_s_rdy", 72'(s_rdy), 72'h1);

        // Single-beat lane-0 packet: first o_stb two edges after acceptance.
        cycle(1'b1, 1'b1, 72'h0_0000_0000_0000_00A5, 2'b00);
        cycle(1'b0, 1'b0, 72'h0, 2'b00);
        chk("t1_latency_gap", 72'(o_stb), 72'h0);
        cycle(1'b0, 1'b0, 72'h0, 2'b00);
        chk("t1_o_stb", 72'(o_stb), 72'h1);
        chk("t1_o_sof", 72'(o_sof), 72'h1);
        chk("t1_o_data", o_data, 72'h0_0000_0000_0000_00A5);
        cycle(1'b0, 1'b0, 72'h0, 2'b00);
        chk("t1_single", 72'(o_stb), 72'h0);
        idle(3, 2'b00);

        // 4-beat lane-1 packet held off by af, then released.
        do_reset();
        hdr = mk_hdr(1'b1, 4'd3, 60'h111);
        bd[0] = 72'hB1_0000_0000_0000_0001;
        bd[1] = 72'hB2_0000_0000_0000_0002;
        bd[2] = 72'hB3_0000_0000_0000_0003;
        cycle(1'b1, 1'b1, hdr, 2'b10);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, bd[i], 2'b10);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 72'h0, 2'b10);
            chk("t2_af_hold", 72'(o_stb), 72'h0);
        end
        cycle(1'b0, 1'b0, 72'h0, 2'b00);
        chk("t2_b0_stb", 72'(o_stb), 72'h1);
        chk("t2_b0_sof", 72'(o_sof), 72'h1);
        chk("t2_b0_data", o_data, hdr);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 72'h0, 2'b00);
            chk("t2_body_stb", 72'(o_stb), 72'h1);
            chk("t2_body_sof", 72'(o_sof), 72'h0);
            chk("t2_body_data", o_data, bd[i]);
        end
        cycle(1'b0, 1'b0, 72'h0, 2'b00);
        chk("t2_end", 72'(o_stb), 72'h0);

        // Both lanes ready: lane 1 first, one idle cycle, then lane 0.
        do_reset();
        h0 = mk_hdr(1'b0, 4'd0, 60'hAAA);
        h1 = mk_hdr(1'b1, 4'd0, 60'hBBB);
        cycle(1'b1, 1'b1, h0, 2'b11);
        cycle(1'b1, 1'b1, h1, 2'b11);
        idle(3, 2'b11);
        cycle(1'b0, 1'b0, 72'h0, 2'b00);
        chk("t3_first_lane1", o_data, h1);
        chk("t3_first_stb", 72'(o_stb), 72'h1);
        cycle(1'b0, 1'b0, 72'h0, 2'b00);
        chk("t3_gap", 72'(o_stb), 72'h0);
        cycle(1'b0, 1'b0, 72'h0, 2'b00);
        chk("t3_second_stb", 72'(o_stb), 72'h1);
        chk("t3_second_lane0", o_data, h0);
        idle(2, 2'b00);

        // s_rdy boundary: 17 lane-0 beats leave 15 free entries.
        do_reset();
        for (int i = 0; i < 16; i++)
            cycle(1'b1, (i == 0), (i == 0) ? mk_hdr(1'b0, 4'd15, 60'h5) : 72'(i), 2'b01);
        chk("t4_rdy_16", 72'(s_rdy), 72'h1);
        cycle(1'b1, 1'b1, mk_hdr(1'b0, 4'd0, 60'h6), 2'b01);
        chk("t4_rdy_17", 72'(s_rdy), 72'h0);
        idle(25, 2'b00);
        chk("t4_rdy_drained", 72'(s_rdy), 72'h1);

        // Stray sof=0 beat sets a sticky error; reset mid-packet kills output.
        do_reset();
        cycle(1'b1, 1'b0, 72'h5, 2'b00);
        chk("t5_err_set", 72'(ff_err), 72'h1);
        idle(5, 2'b00);
        chk("t5_err_sticky", 72'(ff_err), 72'h1);
        chk("t5_no_output", 72'(o_stb), 72'h0);
        cycle(1'b1, 1'b1, mk_hdr(1'b1, 4'd7, 60'h77), 2'b00);
        for (int i = 1; i < 8; i++) cycle(1'b1, 1'b0, 72'(i), 2'b00);
        idle(3, 2'b00);
        chk("t5_sending", 72'(o_stb), 72'h1);
        rst = 1'b1;
        #1;
        chk("t5_rst_o_stb", 72'(o_stb), 72'h0);
        chk("t5_rst_err", 72'(ff_err), 72'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        idle(12, 2'b00);
        chk("t5_no_partial", 72'(o_stb), 72'h0);

        // Lane-0 starvation: count lane-1 packets sent before the pending lane-0 packet.
        do_reset();
        cycle(1'b1, 1'b1, mk_hdr(1'b0, 4'd0, 60'hC0), 2'b11);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, mk_hdr(1'b1, 4'd0, 60'(i)), 2'b11);
        idle(2, 2'b11);
        n1 = 0;
        found = 0;
        for (int i = 0; i < 60 && found == 0; i++) begin
            cycle(1'b0, 1'b0, 72'h0, 2'b00);
            if (o_stb === 1'b1 && o_sof === 1'b1) begin
                if (o_data[64] === 1'b0) found = 1;
                else n1++;
            end
        end
`ifdef RSBUS_TX_AGING_EN
        exp_n1 = AGE_LIMIT;
`else
        exp_n1 = 6;
`endif
        chk("t6_lane0_seen", 72'(found), 72'h1);
        chk("t6_lane1_before_lane0", 72'(n1), 72'(exp_n1));
        idle(4, 2'b00);

        // Randomized traffic with randomized backpressure and occasional protocol errors.
        do_reset();
        cur_af = 2'b00;
        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) do_reset();
            if (gq.size() == 0 && $urandom_range(0, 2) == 0) gen_pkt();
            if ($urandom_range(0, 15) == 0)
                cur_af = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom_range(0, 3));
            stb = (gq.size() > 0) && ($urandom_range(0, 3) != 0);
            ent = stb ? gq[0] : 73'h0;
            acc = stb && m_rdy();
            cycle(stb, ent[72], ent[71:0], cur_af);
            if (acc) void'(gq.pop_front());
        end
        idle(60, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
